serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_if.sv | 24 ++
 rtl/serial_add_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: handshake and operand/result bundle for the bit-serial adder.
// The optional carry-in wire exists only when SERIAL_ADD_CARRY_IN_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_CARRY_IN_EN
  logic             cin;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_CARRY_IN_EN
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, LSB first, one bit per clock, built around a
// single full-adder cell made of two half adders and an OR gate.
// IDLE -> RUN (WIDTH cycles) -> DONE (one-cycle done pulse) -> IDLE, or straight
// back to RUN when a new start arrives in DONE.
// Optional feature: define SERIAL_ADD_CARRY_IN_EN to add a carry-in (bus.cin)
// that seeds the carry flop when an addition is accepted.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             step;
  logic             last_bit;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic             cin_init;
  logic             ha0_s;
  logic             ha0_c;
  logic             sum_bit;
  logic             ha1_c;
  logic             carry_next;

`ifdef SERIAL_ADD_CARRY_IN_EN
  assign cin_init = bus.cin;
`else
  assign cin_init = 1'b0;
`endif

  // The one full-adder cell: operand LSBs first, then the running carry.
  half_adder u_ha0 (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .x (ha0_s),
    .y (carry_q),
    .s (sum_bit),
    .c (ha1_c)
  );

  assign carry_next = ha0_c | ha1_c;
  assign last_bit   = (cnt_q == CW'(WIDTH - 1));

  // State register; reset wins over any start seen on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath strobes; start is only looked at in IDLE/DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on acceptance, then add and shift one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      a_sr    <= bus.a;
      b_sr    <= bus.b;
      sum_q   <= '0;
      carry_q <= cin_init;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      sum_q   <= {sum_bit, sum_q[WIDTH-1:1]};
      carry_q <= carry_next;
      cnt_q   <= cnt_q + CW'(1);
      if (last_bit) begin
        cout_q <= carry_next;
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
